// File: rtl/athena_vram_arbiter_if.sv
// athena_vram_arbiter_if: CPU A/B request ports and the shared VRAM bus
interface athena_vram_arbiter_if #(parameter int AW = 13, parameter int DW = 8);
  logic          a_req, a_wr, a_ack, a_wait;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din, a_dout;
  logic          b_req, b_wr, b_ack, b_wait;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din, b_dout;
  logic [AW-1:0] va;
  logic [DW-1:0] vd_w, vd_r;
  logic          v_c, voe, vwe;
  logic [1:0]    gnt;
  modport master(
    output a_req, a_wr, a_addr, a_din, b_req, b_wr, b_addr, b_din, vd_r,
    input  a_dout, a_ack, a_wait, b_dout, b_ack, b_wait, va, vd_w, v_c, voe, vwe, gnt
  );
  modport slave(
    input  a_req, a_wr, a_addr, a_din, b_req, b_wr, b_addr, b_din, vd_r,
    output a_dout, a_ack, a_wait, b_dout, b_ack, b_wait, va, vd_w, v_c, voe, vwe, gnt
  );
endinterface

// File: rtl/athena_vram_arbiter.sv
// athena_vram_arbiter: shares the VRAM bus between video scan and round-robin CPU A/B
module athena_vram_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int ACC_CEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cen,
  input  logic vid_slot,
  athena_vram_arbiter_if.slave bus
);
  localparam int CW = ACC_CEN > 1 ? $clog2(ACC_CEN) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d, last_q, last_d, susp_q, susp_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [AW-1:0] va_q, va_d;
  logic [DW-1:0] vd_w_q, vd_w_d, a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          pick_b, v_c;
  // last_q: 0 = A, 1 = B; ties go to whichever was not granted last
  assign pick_b = bus.b_req & ~(bus.a_req & last_q);
  // video ownership follows vid_slot on a cen and holds until the next cen
  assign v_c = (state_q != ACCESS) | (cen ? vid_slot : susp_q);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    last_d   = last_q;
    susp_d   = susp_q;
    va_d     = va_q;
    vd_w_d   = vd_w_q;
    gnt_d    = gnt_q;
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    case (state_q)
      IDLE: if (cen && !vid_slot && (bus.a_req || bus.b_req)) begin
        state_d = ACCESS;
        cnt_d   = CW'(ACC_CEN - 1);
        wr_d    = pick_b ? bus.b_wr : bus.a_wr;
        va_d    = pick_b ? bus.b_addr : bus.a_addr;
        vd_w_d  = pick_b ? bus.b_din : bus.a_din;
        gnt_d   = pick_b ? 2'b10 : 2'b01;
        last_d  = pick_b;
        susp_d  = 1'b0;
      end
      ACCESS: if (cen) begin
        susp_d = vid_slot;
        if (!vid_slot && cnt_q == '0) begin
          state_d  = DONE;
          gnt_d    = 2'b00;
          a_ack_d  = gnt_q[0];
          b_ack_d  = gnt_q[1];
          a_dout_d = (gnt_q[0] && !wr_q) ? bus.vd_r : a_dout_q;
          b_dout_d = (gnt_q[1] && !wr_q) ? bus.vd_r : b_dout_q;
        end else if (!vid_slot) cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      last_q   <= 1'b1;
      susp_q   <= 1'b0;
      va_q     <= '0;
      vd_w_q   <= '0;
      gnt_q    <= 2'b00;
      a_dout_q <= '1;
      b_dout_q <= '1;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      last_q   <= last_d;
      susp_q   <= susp_d;
      va_q     <= va_d;
      vd_w_q   <= vd_w_d;
      gnt_q    <= gnt_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
    end
  end
  assign bus.va     = va_q;
  assign bus.vd_w   = vd_w_q;
  assign bus.v_c    = v_c;
  assign bus.voe    = ~v_c & ~wr_q;
  assign bus.vwe    = ~v_c & wr_q;
  assign bus.gnt    = gnt_q;
  assign bus.a_dout = a_dout_q;
  assign bus.b_dout = b_dout_q;
  assign bus.a_ack  = a_ack_q;
  assign bus.b_ack  = b_ack_q;
  assign bus.a_wait = bus.a_req & ~a_ack_q;
  assign bus.b_wait = bus.b_req & ~b_ack_q;
endmodule

// File: tb/tb_athena_vram_arbiter.sv
// tb_athena_vram_arbiter: directed vectors with hand-computed expectations
module tb_athena_vram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cen = 1'b0;
  logic vid_slot = 1'b0;
  int total = 0;
  int bad = 0;
  int acnt = 0;
  int bcnt = 0;
  logic s_vc, s_voe, s_vwe, s_vc2, s_aack, s_back;
  logic [1:0] s_gnt;
  athena_vram_arbiter_if #(.AW(13), .DW(8)) bus();
  athena_vram_arbiter #(.AW(13), .DW(8), .ACC_CEN(2)) dut (
    .clk(clk), .reset(reset), .cen(cen), .vid_slot(vid_slot), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cen = 1'b0;
    vid_slot = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acnt = 0;
    bcnt = 0;
  endtask
  task automatic pulse(input logic v);
    cen = 1'b1;
    vid_slot = v;
    #1;
    s_vc  = bus.v_c;
    s_voe = bus.voe;
    s_vwe = bus.vwe;
    @(posedge clk);
    @(negedge clk);
    cen = 1'b0;
    vid_slot = 1'b0;
    #1;
    s_gnt  = bus.gnt;
    s_vc2  = bus.v_c;
    s_aack = bus.a_ack;
    s_back = bus.b_ack;
    if (s_aack) acnt++;
    if (s_back) bcnt++;
    @(posedge clk);
    @(negedge clk);
    if (s_aack) bus.a_req = 1'b0;
    if (s_back) bus.b_req = 1'b0;
  endtask
  initial begin
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = '0; bus.b_din = '0;
    bus.vd_r = 8'hff;
    @(negedge clk);
    do_reset();
    #1;
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_vc", bus.v_c, 1'b1);
    check("rst_voe", bus.voe, 1'b0);
    check("rst_vwe", bus.vwe, 1'b0);
    check("rst_va", bus.va, 13'h0);
    check("rst_vdw", bus.vd_w, 8'h00);
    check("rst_adout", bus.a_dout, 8'hff);
    check("rst_bdout", bus.b_dout, 8'hff);
    check("rst_ack", {bus.a_ack, bus.b_ack}, 2'b00);
    // A read alone
    bus.vd_r = 8'h5a;
    bus.a_addr = 13'h0abc; bus.a_wr = 1'b0; bus.a_req = 1'b1;
    pulse(1'b0);
    check("t1_gnt", s_gnt, 2'b01);
    check("t1_vc_gnt", s_vc2, 1'b0);
    check("t1_va", bus.va, 13'h0abc);
    check("t1_wait", bus.a_wait, 1'b1);
    pulse(1'b0);
    check("t1_voe1", s_voe, 1'b1);
    check("t1_ack_early", s_aack, 1'b0);
    pulse(1'b0);
    check("t1_voe2", s_voe, 1'b1);
    check("t1_ack", s_aack, 1'b1);
    check("t1_vc_done", s_vc2, 1'b1);
    check("t1_gnt_done", s_gnt, 2'b00);
    check("t1_ack_one", bus.a_ack, 1'b0);
    check("t1_dout", bus.a_dout, 8'h5a);
    // Contention alternates A,B,A,B
    do_reset();
    bus.b_addr = 13'h0111; bus.b_wr = 1'b0;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0);
      check("t2_alt", s_gnt, (i % 2) ? 2'b10 : 2'b01);
      pulse(1'b0);
      pulse(1'b0);
      check("t2_ack", {s_back, s_aack}, (i % 2) ? 2'b10 : 2'b01);
      bus.a_req = 1'b1; bus.b_req = 1'b1;
    end
    check("t2_acnt", acnt, 2);
    check("t2_bcnt", bcnt, 2);
    // B write suspended by a video slot
    do_reset();
    bus.b_addr = 13'h1234; bus.b_din = 8'hc3; bus.b_wr = 1'b1; bus.b_req = 1'b1;
    pulse(1'b0);
    check("t3_gnt", s_gnt, 2'b10);
    check("t3_va", bus.va, 13'h1234);
    check("t3_vdw", bus.vd_w, 8'hc3);
    pulse(1'b1);
    check("t3_vc_vid", s_vc, 1'b1);
    check("t3_vwe_vid", s_vwe, 1'b0);
    check("t3_vc_hold", s_vc2, 1'b1);
    pulse(1'b0);
    check("t3_vc_res", s_vc, 1'b0);
    check("t3_vwe1", s_vwe, 1'b1);
    check("t3_ack_early", s_back, 1'b0);
    pulse(1'b0);
    check("t3_vwe2", s_vwe, 1'b1);
    check("t3_voe", s_voe, 1'b0);
    check("t3_ack", s_back, 1'b1);
    pulse(1'b0);
    pulse(1'b0);
    check("t3_bcnt", bcnt, 1);
    check("t3_bdout", bus.b_dout, 8'hff);
    // Video owns every cen
    do_reset();
    bus.a_wr = 1'b0; bus.a_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1);
      check("t4_gnt", s_gnt, 2'b00);
      check("t4_wait", bus.a_wait, 1'b1);
    end
    check("t4_acnt", acnt, 0);
    // Reset mid-access of an A write
    do_reset();
    bus.a_addr = 13'h0055; bus.a_din = 8'h77; bus.a_wr = 1'b1; bus.a_req = 1'b1;
    pulse(1'b0);
    pulse(1'b0);
    check("t5_vwe_pre", bus.vwe, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_gnt", bus.gnt, 2'b00);
    check("t5_vwe", bus.vwe, 1'b0);
    check("t5_vc", bus.v_c, 1'b1);
    check("t5_ack", bus.a_ack, 1'b0);
    check("t5_dout", bus.a_dout, 8'hff);
    pulse(1'b0);
    check("t5_regrant", s_gnt, 2'b01);
    pulse(1'b0);
    pulse(1'b0);
    check("t5_ack_end", s_aack, 1'b1);
    // A drops request after grant
    do_reset();
    bus.vd_r = 8'h3c; bus.a_wr = 1'b0; bus.a_req = 1'b1;
    pulse(1'b0);
    check("t6_gnt", s_gnt, 2'b01);
    bus.a_req = 1'b0;
    pulse(1'b0);
    pulse(1'b0);
    check("t6_ack", s_aack, 1'b1);
    check("t6_dout", bus.a_dout, 8'h3c);
    pulse(1'b0);
    check("t6_nogrant", s_gnt, 2'b00);
    pulse(1'b0);
    check("t6_acnt", acnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
